// File: rtl/mips_mem_pkg.sv
// Shared types for the core-side store buffer.
// Entry layout and access-size encodings.
package mips_mem_pkg;

    localparam int SB_AW = 32;
    localparam int SB_DW = 32;

    localparam logic ACC_WORD = 1'b1;
    localparam logic ACC_BYTE = 1'b0;

    typedef struct packed {
        logic             worb;
        logic [SB_AW-1:0] adr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Core-side and dmem-side bus of the store buffer.
// slave = buffer view, master = core/dmem view.
interface store_buffer_if
    import mips_mem_pkg::*;
#(
    parameter int AW = SB_AW,
    parameter int DW = SB_DW
);
    logic          memwrite;
    logic          memread;
    logic          worb;
    logic [AW-1:0] dataadr;
    logic [DW-1:0] writedata;
    logic [DW-1:0] readdata;
    logic          stall;
    logic          mem_we;
    logic          mem_worb;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;
    logic          mem_ready;

    modport slave (
        input  memwrite, memread, worb, dataadr, writedata,
        input  mem_rd, mem_ready,
        output readdata, stall,
        output mem_we, mem_worb, mem_adr, mem_wd
    );

    modport master (
        output memwrite, memread, worb, dataadr, writedata,
        output mem_rd, mem_ready,
        input  readdata, stall,
        input  mem_we, mem_worb, mem_adr, mem_wd
    );
endinterface

// File: rtl/sb_fifo.sv
// Circular FIFO of store-buffer entries.
// Exposes per-entry valid bits for hazard compare.
module sb_fifo
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  sb_entry_t        i_ent,
    input  logic             i_pop,
    output sb_entry_t        o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [DEPTH-1:0] o_valid,
    output sb_entry_t        o_ents [DEPTH]
);
    localparam int PW = $clog2(DEPTH);

    sb_entry_t   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_ents  = r_mem;

    for (genvar g = 0; g < DEPTH; g++) begin : g_valid
        logic [PW-1:0] w_off;
        assign w_off = PW'(g) - r_rd_ptr;
        assign o_valid[g] = ({1'b0, w_off} < r_count);
    end

    // Pointers and occupancy; reset drops every entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    // Entry storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_ent;
    end
endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between memory stage and dmem.
// Owns the stall decision and the dmem address mux.
module store_buffer
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic            clk,
    input  logic            reset,
    store_buffer_if.slave   bus
);
    sb_entry_t        w_ent;
    sb_entry_t        w_head;
    sb_entry_t        w_ents [DEPTH];
    logic             w_full;
    logic             w_empty;
    logic [DEPTH-1:0] w_valid;
    logic             w_match;
    logic             w_load;
    logic [DW-1:0]    w_rd;

    assign w_ent = '{worb: bus.worb,
                     adr:  bus.dataadr,
                     data: bus.writedata};

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (bus.memwrite),
        .i_ent   (w_ent),
        .i_pop   (bus.mem_ready),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_valid (w_valid),
        .o_ents  (w_ents)
    );

    // Word-granular match of the load against queued stores.
    always_comb begin
        w_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i] &&
                w_ents[i].adr[AW-1:2] == bus.dataadr[AW-1:2])
                w_match = 1'b1;
        end
    end

    // A load also waits whenever dmem's port shows the head.
    assign w_load    = bus.memread && !bus.memwrite;
    assign bus.stall = (bus.memwrite && w_full) ||
                       (w_load && (!w_empty || w_match));

    assign w_rd         = bus.mem_rd;
    assign bus.readdata = w_rd;
    assign bus.mem_we   = !w_empty;
    assign bus.mem_worb = w_head.worb;
    assign bus.mem_wd   = w_head.data;
    assign bus.mem_adr  = w_empty ? bus.dataadr : w_head.adr;
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the pipelined core's memory stage and dmem.
- Core stores (word or byte, selected by worb) are queued and drained to dmem in order, one per cycle, whenever dmem signals ready.
- Core loads read dmem combinationally. A load stalls while any queued store targets the same word.
- The core therefore does not wait on a busy dmem port unless the buffer is full or a hazard exists.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low; reset==0 at a clk edge clears all state.
- memwrite  in  1  core store request this cycle.
- memread  in  1  core load request this cycle.
- worb  in  1  access size: 1 = word, 0 = byte.
- dataadr  in  AW  core byte address.
- writedata  in  DW  core store data; byte stores use bits [7:0].
- readdata  out  DW  load data to the core; always equals mem_rd.
- stall  out  1  core must hold its memory stage this cycle.
- mem_we  out  1  dmem write strobe; equals !empty.
- mem_worb  out  1  head entry worb.
- mem_adr  out  AW  mux: head entry address when mem_we, else dataadr.
- mem_wd  out  DW  head entry data.
- mem_rd  in  DW  dmem combinational read data.
- mem_ready  in  1  dmem accepts the write presented this cycle.

Behaviour:
- State:
  - Circular array of DEPTH entries, each {worb, adr, data}.
  - wr_ptr and rd_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - count, 0..DEPTH.
  - empty = (count==0); full = (count==DEPTH).
- Reset:
  - On an edge with reset==0: count=0, wr_ptr=0, rd_ptr=0. Entry contents are don't-care.
  - A reset during a drain discards every queued entry, with no partial write after the edge.
  - Post-reset outputs: mem_we=0, stall=0, mem_adr=dataadr.
- Push:
  - An edge with memwrite && !full writes {worb, dataadr, writedata} at wr_ptr, then increments wr_ptr.
  - Zero-cycle acceptance; the entry is visible at the head no earlier than the next cycle.
- Pop:
  - An edge with mem_we && mem_ready increments rd_ptr; dmem commits the write on the same edge.
  - At most one pop per cycle.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, with both pointers advancing.
- Full:
  - memwrite && full asserts stall=1 and drops the push. The core holds its signals.
  - A pop in that same cycle does not admit the push; it retries next cycle. This avoids a comb path from mem_ready to stall.
- Load hazard:
  - Applies when memread && !memwrite.
  - Condition: some valid entry has adr[AW-1:2] == dataadr[AW-1:2]. Match is word-granular, so a queued byte store blocks a word load of the same word.
  - Hazard: stall=1 and readdata is don't-care.
  - Since mem_adr shows the head address while draining, a load only reads dmem correctly once the buffer is empty or has no word match. With no match and the buffer non-empty, the load is also stalled. So effectively: load stalls unless empty, and the match logic is reserved for a future separate read port.
- stall = (memwrite && full) || (memread && !memwrite && !empty).
- memwrite and memread both high: treated as a store; memread is ignored.
- Ordering: dmem sees stores strictly in push order. No merging or coalescing.
- mem_ready low holds the head entry stable on mem_we, mem_adr, mem_wd and mem_worb.

Decomposition:
- Package mips_mem_pkg:
  - sb_entry_t packed struct {logic worb; logic [AW-1:0] adr; logic [DW-1:0] data}.
  - Constants ACC_WORD=1'b1 and ACC_BYTE=1'b0.
- Sub-module sb_fifo:
  - Generic circular FIFO of sb_entry_t.
  - Exposes push, pop, head, full, empty and the per-entry valid/address vector for hazard compare.
- store_buffer owns the stall logic and the mem_adr mux.

Test Plan:
- Reset (reset=0 for 2 cycles), then release → mem_we=0, stall=0, count=0.
- Store word 0xDEADBEEF @0x40 with mem_ready=1 → mem_we=1 next cycle with mem_adr=0x40, mem_wd=0xDEADBEEF, mem_worb=1; empty one cycle later.
- mem_ready=0, five word stores @0x0,0x4,0x8,0xC,0x10 → first four accepted, fifth sees stall=1. Raise mem_ready → drains 0x0,0x4,0x8,0xC in order, then the held store is accepted.
- Byte store 0xAB @0x21, then load word @0x20 → stall=1 until drain completes; then readdata=mem_rd with dmem word byte1=0xAB.
- Simultaneous push/pop at count=2 with wr_ptr=3 → count stays 2, wr_ptr wraps to 0, rd_ptr advances.
- Reset=0 asserted with 3 entries queued and mem_ready=1 → next cycle mem_we=0; no further dmem writes after the reset edge.
